// File: rtl/perm_product_if.sv
// perm_product_if: request/result bundle for the perm_product coprocessor.
// The master side (core or bench) drives start/n/k.
// The slave side (perm_product) returns busy/done/fn/ovf.
interface perm_product_if #(
  parameter int unsigned N_WIDTH  = 8,
  parameter int unsigned FN_WIDTH = 32
);
  logic                start;
  logic [N_WIDTH-1:0]  n;
  logic [N_WIDTH-1:0]  k;
  logic                busy;
  logic                done;
  logic [FN_WIDTH-1:0] fn;
  logic                ovf;

  modport master (
    output start, n, k,
    input  busy, done, fn, ovf
  );

  modport slave (
    input  start, n, k,
    output busy, done, fn, ovf
  );
endinterface

// File: rtl/perm_product.sv
// perm_product: iterative falling product P(n,k) = n*(n-1)*...*(n-k+1).
// Performs one multiply per cycle, and the result is held until the next completion.
// With k == 0 the result is 1 (empty product).
// With k > n the result is 0, because a zero factor is crossed.
// Optional build macro: PERM_PRODUCT_OVF_EN.
//   When defined, an overflowing product saturates to all ones, sets ovf and ends the job early.
//   When undefined, the product wraps modulo 2^FN_WIDTH and ovf is tied to 0.
module perm_product #(
  parameter int unsigned N_WIDTH  = 8,
  parameter int unsigned FN_WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  perm_product_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] ITER = 2'd2;
  localparam logic [1:0] STOR = 2'd3;

  logic [1:0]          state;
  logic [N_WIDTH-1:0]  nq;
  logic [N_WIDTH-1:0]  kq;
  logic [N_WIDTH-1:0]  a;
  logic [N_WIDTH-1:0]  cnt;
  logic [FN_WIDTH-1:0] p;
  logic [FN_WIDTH-1:0] prod;
  logic [FN_WIDTH-1:0] fn_q;
  logic                done_q;

`ifdef PERM_PRODUCT_OVF_EN
  localparam int unsigned PW = N_WIDTH + FN_WIDTH;

  logic [PW-1:0] full;
  logic          sat;
  logic          ovf_int;
  logic          ovf_q;

  // Full-width product; any set bit above FN_WIDTH means the result no longer fits.
  always_comb begin
    full = PW'(p) * PW'(a);
    prod = full[FN_WIDTH-1:0];
    sat  = |full[PW-1:FN_WIDTH];
  end
`else
  // Truncated product; the result wraps modulo 2^FN_WIDTH.
  always_comb begin
    prod = p * FN_WIDTH'(a);
  end
`endif

  // Control FSM and datapath: capture the operands, seed the product, then multiply down once per cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      nq      <= '0;
      kq      <= '0;
      a       <= '0;
      p       <= '0;
      cnt     <= '0;
`ifdef PERM_PRODUCT_OVF_EN
      ovf_int <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            nq    <= bus.n;
            kq    <= bus.k;
            state <= LOAD;
          end
        end
        LOAD: begin
          a   <= nq;
          cnt <= kq;
`ifdef PERM_PRODUCT_OVF_EN
          ovf_int <= 1'b0;
`endif
          // The degenerate cases skip ITER entirely and store their fixed result.
          if (kq == '0) begin
            p     <= FN_WIDTH'(1);
            state <= STOR;
          end else if (kq > nq) begin
            p     <= '0;
            state <= STOR;
          end else begin
            p     <= FN_WIDTH'(1);
            state <= ITER;
          end
        end
        ITER: begin
          a   <= a - N_WIDTH'(1);
          cnt <= cnt - N_WIDTH'(1);
`ifdef PERM_PRODUCT_OVF_EN
          if (sat) begin
            p       <= '1;
            ovf_int <= 1'b1;
            state   <= STOR;
          end else begin
            p <= prod;
            if (cnt == N_WIDTH'(1)) state <= STOR;
          end
`else
          p <= prod;
          if (cnt == N_WIDTH'(1)) state <= STOR;
`endif
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Result registers: load on the edge that leaves STOR; done pulses for that one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_q <= 1'b0;
      fn_q   <= '0;
`ifdef PERM_PRODUCT_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else begin
      done_q <= (state == STOR);
      if (state == STOR) begin
        fn_q  <= p;
`ifdef PERM_PRODUCT_OVF_EN
        ovf_q <= ovf_int;
`endif
      end
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = done_q;
  assign bus.fn   = fn_q;
`ifdef PERM_PRODUCT_OVF_EN
  assign bus.ovf  = ovf_q;
`else
  assign bus.ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_perm_product.sv
// tb_perm_product: directed bench for perm_product with hand-computed results.
module tb_perm_product;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  perm_product_if #(.N_WIDTH(8), .FN_WIDTH(32)) bus ();

  perm_product #(.N_WIDTH(8), .FN_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive operands with start high and let the next rising edge sample them.
  // Returns at 1 time unit after that sampling edge, with start low again.
  task automatic launch(input logic [7:0] nv, input logic [7:0] kv);
    bus.n     = nv;
    bus.k     = kv;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Count the cycles until done is seen; lat stays -1 if the bound expires.
  task automatic wait_done(input int limit, output int lat);
    lat = -1;
    for (int c = 1; c <= limit; c++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.n     = '0;
    bus.k     = '0;
    #3;
    checks++;
    if ({bus.busy, bus.done, bus.ovf} !== 3'b000 || bus.fn !== 32'd0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b ovf=%b fn=%0d, required all 0",
               bus.busy, bus.done, bus.ovf, bus.fn);
    end
    #9;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_factorial;
    int lat;
    launch(8'd5, 8'd5);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL fact_busy: busy=%b, required 1", bus.busy);
    end
    wait_done(50, lat);
    checks++;
    if (lat != 7) begin
      errors++;
      $display("FAIL fact_latency: got %0d, required 7", lat);
    end
    checks++;
    if (bus.fn !== 32'd120 || bus.ovf !== 1'b0) begin
      errors++;
      $display("FAIL fact_result: fn=%0d ovf=%b, required 120 ovf 0", bus.fn, bus.ovf);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL fact_done_pulse: done=%b busy=%b, required 0 0", bus.done, bus.busy);
    end
  endtask

  task automatic test_partial;
    int lat;
    launch(8'd7, 8'd3);
    wait_done(50, lat);
    checks++;
    if (lat != 5 || bus.fn !== 32'd210) begin
      errors++;
      $display("FAIL partial_7_3: lat=%0d fn=%0d, required 5 210", lat, bus.fn);
    end
    @(posedge clk);
    #1;
    launch(8'd0, 8'd0);
    wait_done(50, lat);
    checks++;
    if (lat != 2 || bus.fn !== 32'd1 || bus.ovf !== 1'b0) begin
      errors++;
      $display("FAIL empty_0_0: lat=%0d fn=%0d ovf=%b, required 2 1 0", lat, bus.fn, bus.ovf);
    end
    @(posedge clk);
    #1;
    launch(8'd9, 8'd1);
    wait_done(50, lat);
    checks++;
    if (lat != 3 || bus.fn !== 32'd9) begin
      errors++;
      $display("FAIL single_9_1: lat=%0d fn=%0d, required 3 9", lat, bus.fn);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_k_gt_n;
    int lat;
    launch(8'd3, 8'd4);
    wait_done(50, lat);
    checks++;
    if (lat != 2 || bus.fn !== 32'd0 || bus.ovf !== 1'b0) begin
      errors++;
      $display("FAIL k_gt_n: lat=%0d fn=%0d ovf=%b, required 2 0 0", lat, bus.fn, bus.ovf);
    end
    @(posedge clk);
    #1;
    launch(8'd0, 8'd1);
    wait_done(50, lat);
    checks++;
    if (lat != 2 || bus.fn !== 32'd0) begin
      errors++;
      $display("FAIL n0_k1: lat=%0d fn=%0d, required 2 0", lat, bus.fn);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_overflow;
    int lat;
    launch(8'd13, 8'd13);
    wait_done(50, lat);
`ifdef PERM_PRODUCT_OVF_EN
    // 13*12*...*3 still fits in 32 bits; the 12th multiply (by 2) overflows.
    checks++;
    if (bus.fn !== 32'hFFFFFFFF || bus.ovf !== 1'b1 || lat != 14) begin
      errors++;
      $display("FAIL overflow_sat: fn=%h ovf=%b lat=%0d, required ffffffff 1 14",
               bus.fn, bus.ovf, lat);
    end
`else
    checks++;
    if (bus.fn !== 32'h7328CC00 || bus.ovf !== 1'b0 || lat != 15) begin
      errors++;
      $display("FAIL overflow_wrap: fn=%h ovf=%b lat=%0d, required 7328cc00 0 15",
               bus.fn, bus.ovf, lat);
    end
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic test_handshake;
    int lat;
    // A start during ITER must be ignored.
    launch(8'd6, 8'd6);
    repeat (3) @(posedge clk);
    #1;
    bus.n     = 8'd2;
    bus.k     = 8'd2;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(50, lat);
    checks++;
    if (lat != 4 || bus.fn !== 32'd720) begin
      errors++;
      $display("FAIL ignore_start: lat=%0d fn=%0d, required 4 720", lat, bus.fn);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_not_queued: busy=%b, required 0", bus.busy);
    end
    // Hold start across completion; the second job is sampled on the done cycle.
    bus.n     = 8'd4;
    bus.k     = 8'd2;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    wait_done(50, lat);
    checks++;
    if (lat != 4 || bus.fn !== 32'd12) begin
      errors++;
      $display("FAIL held_first: lat=%0d fn=%0d, required 4 12", lat, bus.fn);
    end
    bus.n = 8'd3;
    bus.k = 8'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL held_relaunch: busy=%b done=%b, required 1 0", bus.busy, bus.done);
    end
    wait_done(50, lat);
    checks++;
    if (lat != 5 || bus.fn !== 32'd6) begin
      errors++;
      $display("FAIL held_second: lat=%0d fn=%0d, required 5 6", lat, bus.fn);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_midop;
    int lat;
    int seen;
    launch(8'd10, 8'd10);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.ovf} !== 3'b000 || bus.fn !== 32'd0) begin
      errors++;
      $display("FAIL reset_midop: busy=%b done=%b ovf=%b fn=%0d, required all 0",
               bus.busy, bus.done, bus.ovf, bus.fn);
    end
    #4;
    rst = 1'b1;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_no_done: active cycles=%0d, required 0", seen);
    end
    launch(8'd4, 8'd4);
    wait_done(50, lat);
    checks++;
    if (lat != 6 || bus.fn !== 32'd24) begin
      errors++;
      $display("FAIL after_reset: lat=%0d fn=%0d, required 6 24", lat, bus.fn);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_factorial();
    test_partial();
    test_k_gt_n();
    test_overflow();
    test_handshake();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/perm_product.md
Name: perm_product

Overview:
- Iterative falling-product unit: computes P(n,k) = n*(n-1)*...*(n-k+1), one multiply per cycle.
- With k = n it returns n!; it is the parametrised successor of the team's fixed factorial engine.
- Adds a k operand, a busy/done handshake, empty-product and k>n handling, and optional overflow saturation.
- Sits as a memory-less coprocessor beside the core; the result is held until the next completion.

Parameters:
- N_WIDTH, 8: width of the n and k operands and of the down-counters.
- FN_WIDTH, 32: width of the product register and the fn result.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- start  input  1  request; sampled only in IDLE.
- n  input  N_WIDTH  unsigned top factor; captured on the start-accept edge.
- k  input  N_WIDTH  unsigned number of factors; captured on the start-accept edge.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse, registered.
- fn  output  FN_WIDTH  result register; updated only on completion.
- ovf  output  1  overflow flag for the last result; registered, updated with fn.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, done=0, fn=0, ovf=0, internal registers a/p/cnt=0. Takes effect immediately; any operation in flight is aborted with no done pulse.
- States: IDLE, LOAD, ITER, STOR, encoded in 2 bits.
- IDLE: busy=0. start=1 captures n into nq and k into kq, then goes to LOAD. start=0 stays in IDLE.
- LOAD: a<=nq, p<=1, cnt<=kq.
  - kq==0 or kq>nq: go to STOR with no multiplies.
  - kq>nq yields p=0 (the zero factor is crossed); p is forced to 0 and ovf_int=0.
  - kq==0 keeps p=1 (empty product).
  - Otherwise go to ITER.
- ITER, per edge: p<=p*a truncated to FN_WIDTH, a<=a-1, cnt<=cnt-1.
  - Leave for STOR on the edge where cnt==1; exactly k multiplies are performed.
- STOR: fn<=p, ovf<=ovf_int, done<=1 on the edge leaving STOR. Return to IDLE.
- done is high for exactly one cycle. It is deasserted on every other edge.
- Latency: done is visible k+2 cycles after the start-sampling edge. For k==0 or k>n it is visible 2 cycles after.
- start while busy=1 is ignored (not queued). start held high across completion re-launches on the first IDLE cycle, i.e. the cycle done is high.
- n and k may change freely after capture; in-flight operands are unaffected.
- Multiplier width: the full product is N_WIDTH+FN_WIDTH bits. Only the low FN_WIDTH bits are stored unless the optional feature is enabled.
- n==0, k==0 gives fn=1. n==0, k>=1 gives fn=0.

Optional Feature:
- Macro: PERM_PRODUCT_OVF_EN.
- When defined:
  - In ITER, if any of the upper N_WIDTH bits of the full product is non-zero, set ovf_int=1 and saturate p to all ones.
  - Then go directly to STOR, terminating early; done therefore arrives earlier than k+2.
  - Result: fn=all ones, ovf=1.
- When undefined:
  - The product wraps modulo 2^FN_WIDTH.
  - ovf is tied to 0, and the overflow compare logic is absent.

Test Plan:
- Basic factorial: reset, then n=5, k=5, start pulsed for 1 cycle -> busy high next cycle; done pulse exactly 7 cycles after the sampling edge; fn=120, ovf=0.
- Partial product: n=7, k=3 -> fn=210, done 5 cycles after sampling. Then n=0, k=0 -> fn=1, done 2 cycles after sampling.
- Boundary k>n: n=3, k=4 -> fn=0, ovf=0, done 2 cycles after sampling, with no ITER cycles observed.
- Overflow with FN_WIDTH=32, n=13, k=13:
  - PERM_PRODUCT_OVF_EN defined -> fn=32'hFFFFFFFF, ovf=1.
  - Undefined -> fn=32'h7328CC00 (13! mod 2^32), ovf=0, done 15 cycles after sampling.
- Handshake: issue start during ITER of an n=6, k=6 job -> ignored, fn=720. Hold start high through done -> the second job begins on the done cycle.
- Reset mid-op: drive rst=0 asynchronously during ITER of n=10, k=10 -> busy, done, fn and ovf drop to 0 immediately. After release, no done pulse appears until a new start.
